// File: rtl/axrm_error_monitor.sv
// Error-distance monitor for the AxRM approximate multiplier: compares approximate
// products against the exact product and accumulates window statistics.
module axrm_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [WIDTH-1:0]   max_a,
  output logic [WIDTH-1:0]   max_b,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   remaining;
  logic               accept;
  logic               clear;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [2*WIDTH-1:0] s1_approx, s1_exact;
  logic [2*WIDTH-1:0] s1_ed;

  logic               s2_valid;
  logic [WIDTH-1:0]   s2_a, s2_b;
  logic [2*WIDTH-1:0] s2_ed;

  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign clear    = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_samples != '0) ? RUN : DONE;
      RUN:        if (accept && remaining == CNT_W'(1)) state_nxt = DRAIN;
      DRAIN:      if (!s1_valid && !s2_valid) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (clear)       remaining <= num_samples;
      else if (accept) remaining <= remaining - 1'b1;
    end
  end

  // Stage 1 captures the sample together with its exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_approx <= approx;
        s1_exact  <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      end
    end
  end

  // |exact - approx| always fits in 2*WIDTH bits since both are unsigned.
  assign s1_ed = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                         : (s1_approx - s1_exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_ed    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a  <= s1_a;
        s2_b  <= s1_b;
        s2_ed <= s1_ed;
      end
    end
  end

  assign sum_wide = {1'b0, sum_ed} + {{(ACC_W+1-2*WIDTH){1'b0}}, s2_ed};
  assign sum_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  // Strict greater-than keeps the earliest sample on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
      err_count <= '0;
    end else if (clear) begin
      sum_ed    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
      err_count <= '0;
    end else if (s2_valid) begin
      sum_ed <= sum_sat;
      if (s2_ed != '0) err_count <= err_count + 1'b1;
      if (s2_ed > max_ed) begin
        max_ed <= s2_ed;
        max_a  <= s2_a;
        max_b  <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_axrm_error_monitor.sv
// Self-checking bench for axrm_error_monitor: table-driven windows on a 32-bit and a
// 16-bit accumulator build, plus hand-written re-arm, hold, reset and stress sequences.
module tb_axrm_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] approx = '0;

  logic        in_ready, busy, done;
  logic [31:0] sum_ed;
  logic [15:0] max_ed;
  logic [7:0]  max_a, max_b;
  logic [15:0] err_count;

  logic        ready16, busy16, done16;
  logic [15:0] sum16, max16;
  logic [7:0]  maxa16, maxb16;
  logic [15:0] err16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned      n;
    logic [3:0][7:0]  av;
    logic [3:0][7:0]  bv;
    logic [3:0][15:0] pv;
    logic [31:0]      sum;
    logic [15:0]      sum16;
    logic [15:0]      maxEd;
    logic [7:0]       maxA;
    logic [7:0]       maxB;
    logic [15:0]      errs;
  } vec_t;

  vec_t vecs[6];

  axrm_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
    .max_a(max_a), .max_b(max_b), .err_count(err_count)
  );

  axrm_error_monitor #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(ready16), .a(a), .b(b), .approx(approx),
    .busy(busy16), .done(done16), .sum_ed(sum16), .max_ed(max16),
    .max_a(maxa16), .max_b(maxb16), .err_count(err16)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSample(input int idx, input int i, input logic [7:0] sa,
                           input logic [7:0] sb, input logic [15:0] sp);
    vecs[idx].av[i] = sa;
    vecs[idx].bv[i] = sb;
    vecs[idx].pv[i] = sp;
  endtask

  task automatic setResult(input int idx, input int unsigned n, input logic [31:0] s,
                           input logic [15:0] s16, input logic [15:0] m,
                           input logic [7:0] ma, input logic [7:0] mb,
                           input logic [15:0] e);
    vecs[idx].n     = n;
    vecs[idx].sum   = s;
    vecs[idx].sum16 = s16;
    vecs[idx].maxEd = m;
    vecs[idx].maxA  = ma;
    vecs[idx].maxB  = mb;
    vecs[idx].errs  = e;
  endtask

  task automatic doStart(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic sendSample(input logic [7:0] sa, input logic [7:0] sb,
                            input logic [15:0] sp);
    logic acc;
    int k;
    a = sa;
    b = sb;
    approx = sp;
    in_valid = 1'b1;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 50) begin
      acc = in_ready;
      tick();
      k++;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    checkOutput("done", {31'd0, done}, 32'd1);
  endtask

  task automatic checkResults(input int idx);
    checkOutput("sum_ed",    sum_ed,             vecs[idx].sum);
    checkOutput("max_ed",    {16'd0, max_ed},    {16'd0, vecs[idx].maxEd});
    checkOutput("max_a",     {24'd0, max_a},     {24'd0, vecs[idx].maxA});
    checkOutput("max_b",     {24'd0, max_b},     {24'd0, vecs[idx].maxB});
    checkOutput("err_count", {16'd0, err_count}, {16'd0, vecs[idx].errs});
    checkOutput("busy",      {31'd0, busy},      32'd0);
    checkOutput("in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("sum16",     {16'd0, sum16},     {16'd0, vecs[idx].sum16});
    checkOutput("max16",     {16'd0, max16},     {16'd0, vecs[idx].maxEd});
    checkOutput("maxa16",    {24'd0, maxa16},    {24'd0, vecs[idx].maxA});
    checkOutput("maxb16",    {24'd0, maxb16},    {24'd0, vecs[idx].maxB});
    checkOutput("err16",     {16'd0, err16},     {16'd0, vecs[idx].errs});
    checkOutput("done16",    {31'd0, done16},    32'd1);
    checkOutput("busy16",    {31'd0, busy16},    32'd0);
    checkOutput("ready16",   {31'd0, ready16},   32'd0);
  endtask

  task automatic applyStimulus(input int idx);
    int unsigned n;
    n = vecs[idx].n;
    doStart(n[15:0]);
    if (n != 0) begin
      checkOutput("done_drop", {31'd0, done}, 32'd0);
      checkOutput("busy_run",  {31'd0, busy}, 32'd1);
    end else begin
      checkOutput("ready_zero_window", {31'd0, in_ready}, 32'd0);
    end
    for (int i = 0; i < int'(n); i++)
      sendSample(vecs[idx].av[i], vecs[idx].bv[i], vecs[idx].pv[i]);
    in_valid = 1'b0;
    checkOutput("ready_after_last", {31'd0, in_ready}, 32'd0);
    waitDone();
    checkResults(idx);
  endtask

  initial begin
    logic [31:0] heldSum;
    int accepts;
    int cycles;
    logic acc;

    // Hand-computed windows: ED per sample noted beside each entry.
    setResult(0, 0, 0, 0, 0, 0, 0, 0);
    setSample(1, 0, 8'd3,   8'd3,   16'd9);      // ED 0
    setSample(1, 1, 8'd3,   8'd3,   16'd7);      // ED 2
    setSample(1, 2, 8'd255, 8'd255, 16'd65000);  // ED 25
    setResult(1, 3, 27, 27, 25, 255, 255, 2);
    setSample(2, 0, 8'd2, 8'd5, 16'd12);         // ED 2
    setSample(2, 1, 8'd4, 8'd1, 16'd2);          // ED 2, tie
    setResult(2, 2, 4, 4, 2, 2, 5, 2);
    for (int i = 0; i < 3; i++) setSample(3, i, 8'd255, 8'd255, 16'd0);  // ED 65025
    setResult(3, 3, 195075, 16'hFFFF, 65025, 255, 255, 3);
    setSample(4, 0, 8'd0,  8'd0,  16'd65535);    // ED 65535
    setSample(4, 1, 8'd10, 8'd10, 16'd90);       // ED 10
    setSample(4, 2, 8'd7,  8'd8,  16'd56);       // ED 0
    setSample(4, 3, 8'd1,  8'd1,  16'd2);        // ED 1
    setResult(4, 4, 65546, 16'hFFFF, 65535, 0, 0, 3);
    setSample(5, 0, 8'd1, 8'd1, 16'd0);          // ED 1
    setResult(5, 1, 1, 1, 1, 1, 1, 1);

    #3;
    checkOutput("rst_done",      {31'd0, done},      32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_ready",     {31'd0, in_ready},  32'd0);
    checkOutput("rst_sum",       sum_ed,             32'd0);
    checkOutput("rst_err_count", {16'd0, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("idle_ready", {31'd0, in_ready}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(v);
      if (v == 1) begin
        // Samples offered outside RUN must be ignored and results held.
        heldSum = sum_ed;
        sendHold();
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        checkOutput("hold_sum",  sum_ed, heldSum);
        checkOutput("hold_err",  {16'd0, err_count}, 32'd2);
      end
    end

    // start while RUN must not reload the window length.
    doStart(16'd2);
    sendSample(8'd9, 8'd9, 16'd0);               // ED 81
    in_valid = 1'b0;
    start = 1'b1;
    num_samples = 16'd5;
    tick();
    start = 1'b0;
    checkOutput("ignore_start_busy", {31'd0, busy}, 32'd1);
    sendSample(8'd1, 8'd2, 16'd3);               // ED 1
    in_valid = 1'b0;
    checkOutput("ignore_start_ready", {31'd0, in_ready}, 32'd0);
    waitDone();
    checkOutput("ignore_start_sum", sum_ed, 32'd82);
    checkOutput("ignore_start_max", {16'd0, max_ed}, 32'd81);
    checkOutput("ignore_start_err", {16'd0, err_count}, 32'd2);

    // Asynchronous reset mid-window discards partial results.
    doStart(16'd4);
    sendSample(8'd20, 8'd20, 16'd0);             // ED 400
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("pre_reset_sum", sum_ed, 32'd400);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sum",   sum_ed,             32'd0);
    checkOutput("mid_rst_max",   {16'd0, max_ed},    32'd0);
    checkOutput("mid_rst_maxa",  {24'd0, max_a},     32'd0);
    checkOutput("mid_rst_err",   {16'd0, err_count}, 32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy},      32'd0);
    checkOutput("mid_rst_ready", {31'd0, in_ready},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(5);

    // Exact-match stress over a full-length window with random gaps.
    doStart(16'd65535);
    accepts = 0;
    cycles = 0;
    while (accepts < 65535 && cycles < 80000) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      approx = {8'd0, a} * {8'd0, b};
      in_valid = ($urandom_range(31) != 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) accepts++;
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput("stress_accepts", accepts, 32'd65535);
    checkOutput("stress_ready",   {31'd0, in_ready}, 32'd0);
    waitDone();
    checkOutput("stress_err", {16'd0, err_count}, 32'd0);
    checkOutput("stress_sum", sum_ed, 32'd0);
    checkOutput("stress_max", {16'd0, max_ed}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic sendHold();
    a = 8'd200;
    b = 8'd200;
    approx = 16'd0;
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
  endtask

endmodule
